// File: rtl/fpu_result_buffer.sv
// Capture FIFO for half-precision FPU results with a valid/ready drain port,
// sticky exception flags and a saturating count of results dropped when full.
module fpu_result_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DW-1:0]            result,
  input  logic                     overflow,
  input  logic                     underflow,
  input  logic                     inexact,
  input  logic                     out_ready,
  input  logic                     clear_sticky,
  output logic                     out_valid,
  output logic [DW+2:0]            out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop,
  output logic [7:0]               drop_count,
  output logic                     sticky_ovf,
  output logic                     sticky_unf,
  output logic                     sticky_inx
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = DW + 3;

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    drop_count_q, drop_count_d;
  logic          sticky_ovf_q, sticky_ovf_d;
  logic          sticky_unf_q, sticky_unf_d;
  logic          sticky_inx_q, sticky_inx_d;

  logic push;
  logic pop;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == (PW + 1)'(DEPTH));
    out_valid = !empty;
    out_data  = empty ? '0 : mem_q[rd_ptr_q];
    count     = count_q;
    // Reset wins over any handshake, so nothing is reported as dropped then.
    pop       = !reset && out_valid && out_ready;
    push      = !reset && in_valid && (!full || pop);
    drop      = !reset && in_valid && full && !pop;
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {result, overflow, underflow, inexact};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  // A flag raised in the same cycle as a clear survives the clear.
  always_comb begin
    sticky_ovf_d = (clear_sticky ? 1'b0 : sticky_ovf_q) | (in_valid & overflow);
    sticky_unf_d = (clear_sticky ? 1'b0 : sticky_unf_q) | (in_valid & underflow);
    sticky_inx_d = (clear_sticky ? 1'b0 : sticky_inx_q) | (in_valid & inexact);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_count_q <= '0;
      sticky_ovf_q <= 1'b0;
      sticky_unf_q <= 1'b0;
      sticky_inx_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_count_q <= drop_count_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_unf_q <= sticky_unf_d;
      sticky_inx_q <= sticky_inx_d;
    end
  end

  assign drop_count = drop_count_q;
  assign sticky_ovf = sticky_ovf_q;
  assign sticky_unf = sticky_unf_q;
  assign sticky_inx = sticky_inx_q;

endmodule

// File: doc/fpu_result_buffer.md
# fpu_result_buffer

Downstream capture stage for the half-precision `fpu`. Each cycle that `in_valid` is high, it samples the FPU's 16-bit `result` and its overflow/underflow/inexact flags into a first-word-fall-through FIFO. A consumer (result logger, checker or host readout) drains the FIFO through a valid/ready handshake. The block also keeps sticky IEEE-style exception flags and a saturating count of results dropped because the FIFO was full.

## Interface
Parameters:
- `DEPTH`, 8: number of FIFO entries. Must be a power of two and at least 2.
- `DW`, 16: FPU result width.

Ports (reset is synchronous and active-high; clock is `clk`):
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  FPU output is valid this cycle
- `result`  in  DW  FPU result
- `overflow`, `underflow`, `inexact`  in  1 each  FPU flags
- `out_ready`  in  1  consumer accepts the head entry
- `clear_sticky`  in  1  clear all sticky flags
- `out_valid`  out  1  FIFO is non-empty
- `out_data`  out  DW+3  head entry, packed as {result, overflow, underflow, inexact}
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `full`, `empty`  out  1 each  occupancy status
- `drop`  out  1  one-cycle pulse when an input is discarded
- `drop_count`  out  8  saturating count of discarded inputs
- `sticky_ovf`, `sticky_unf`, `sticky_inx`  out  1 each  accumulated exception flags

## Operation
- **Storage:** DEPTH×(DW+3) register array. `wr_ptr` and `rd_ptr` are log2(DEPTH) bits wide and wrap modulo DEPTH. `count` is a separate register.
- **Push:** `push = in_valid && (!full || pop)`. A write when full is allowed only if a pop happens in the same cycle.
- **Pop:** `pop = out_valid && out_ready`.
- **Drop:** `drop = in_valid && full && !pop`. The FIFO is unchanged. `drop_count` increments and saturates at 255.
- **Count update:** push only → +1; pop only → −1; push and pop together → unchanged, both pointers advance.
- **Status outputs:**
  - `out_valid = !empty`.
  - `empty = (count == 0)`.
  - `full = (count == DEPTH)`.
  - `out_data = mem[rd_ptr]` when non-empty, otherwise all zeros.
- **Sticky flags:**
  - Each flag ORs in its input on every cycle where `in_valid` is high, including dropped cycles, so status reflects every FPU operation.
  - `clear_sticky` zeroes all three flags.
  - If a clear and a set happen in the same cycle, the set wins for that flag.
- **No bypass:** an input written into an empty FIFO cannot appear on `out_data` in the same cycle.
- **Reset:**
  - Zeroed: `wr_ptr`, `rd_ptr`, `count`, `drop_count`, all sticky flags, `drop`.
  - Resulting outputs: `out_valid`=0, `empty`=1, `full`=0, `out_data`=0.
  - Memory contents are not reset.
  - Reset has priority over `in_valid`, `out_ready` and `clear_sticky`. Reset asserted mid-stream discards all entries in one cycle.

## Timing
- **Write latency:** 1 cycle. An entry sampled at edge N is visible on `out_valid`/`out_data` during cycle N+1.
- **Head update:** a pop at edge N presents the next entry (or empty) during cycle N+1. `out_data` changes only after a pop or after a push into an empty FIFO.
- **`drop` timing:** combinational in the cycle where the drop occurs. `drop_count` updates at the following edge.
- **Full throughput:** one push and one pop per cycle, at any occupancy including full.
- **Wrap-around:** pointers wrap from DEPTH−1 to 0 with no bubble.
- **Consumer rule:** the consumer may hold `out_ready` high continuously. `out_data` must not change while `out_valid && !out_ready`.

## Test plan
- **Reset, then single push:** reset for 1 cycle, then push one entry {16'h3C00, 0,0,1}.
  - After reset: `empty`=1, `count`=0, `out_data`=0.
  - Cycle after push: `out_valid`=1, `out_data`=19'h1E001, `sticky_inx`=1.
- **Fill and overflow, no reads:** push 9 entries, values 16'h0001 through 16'h0009, with `out_ready`=0.
  - `full`=1 after the 8th push.
  - The 9th push pulses `drop` and `drop_count` becomes 1.
  - Draining afterwards returns 0001..0008 in order.
- **Push and pop while full:** with the FIFO full, push 16'h00AA and pop in the same cycle.
  - `count` stays 8, `drop`=0.
  - Draining returns 0002..0008, then 00AA.
- **Streaming across wrap-around:** hold `out_ready`=1 and stream 20 back-to-back pushes, values 1..20.
  - `out_data` follows the input with 1-cycle lag.
  - `count` never exceeds 1 and no drops occur.
- **Sticky flags:**
  - Push an input with `overflow`=1 → `sticky_ovf`=1.
  - Assert `clear_sticky` alone → `sticky_ovf`=0.
  - Assert `clear_sticky` together with an input having `underflow`=1 → `sticky_unf`=1.
- **Saturation and reset mid-operation:**
  - With the FIFO full, drive 300 dropped inputs → `drop_count` holds at 255.
  - Assert reset mid-stream → `count`=0 and `drop_count`=0 the next cycle.
